ahb_lite_multi_master: RTL and testbench
========================================

Name: ahb_lite_multi_master

Overview:
- Parametrised successor to the two-channel instruction/data memory request interface.
- Arbitrates NCH datapath request channels onto one AHB-Lite master port, with byte/half/word sizing.
- Pipelines the address phase of the next transfer under the current data phase.
- Reports completion and bus error per channel.
- Sits between the core (fetch, load/store, future DMA/debug channels) and the AHB-Lite interconnect.

Parameters:
- NCH, 2, number of request channels; channel 0 is the instruction channel by convention.
- AW, 32, address width.
- DW, 32, data width (fixed 32 in this generation; other values unsupported).
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_read  in  NCH  per-channel read request.
- req_write  in  2*NCH  per-channel write size: 00 none, 01 byte, 10 half, 11 word.
- req_addr  in  AW*NCH  per-channel address.
- req_wdata  in  DW*NCH  per-channel store data, byte-lane aligned.
- req_hit  out  NCH  one-cycle completion pulse.
- req_err  out  NCH  one-cycle error flag, coincident with req_hit.
- req_rdata  out  DW  read data; valid when any req_hit is high for a read.
- haddr  out  AW  AHB address.
- htrans  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size: 000 byte, 001 half, 010 word.
- hburst  out  3  constant 000 (SINGLE).
- hwdata  out  DW  AHB write data.
- hrdata  in  DW  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB error response.

Behaviour:
- Reset, applied at the next clk edge with rst high:
  - htrans=IDLE; haddr, hwrite, hsize, hwdata = 0.
  - req_hit, req_err = 0.
  - Data-phase valid cleared; round-robin pointer = 0.
- Request rules:
  - A request is read if req_read is set, or write if req_write != 00; write wins if both are set.
  - A requester holds its request and operands stable until its req_hit.
  - A read request has size word.
- Eligibility:
  - A channel is eligible when it is requesting and is not the channel currently in data phase.
  - A granted channel's address phase is driven with htrans=NONSEQ.
- Grant lock:
  - While a NONSEQ address phase is pending with hready low, haddr, htrans, hwrite and hsize are held and the grant does not change.
  - Re-arbitration happens only on a cycle where hready is high.
- Address acceptance (NONSEQ and hready high at an edge):
  - The channel index, write flag and store data are latched into the data-phase register.
  - hwdata is driven from the latched store data during the data phase.
- Pipelining:
  - In the same acceptance cycle, the arbiter may present the next eligible channel's address.
  - Back-to-back transfers from different channels therefore complete one per cycle with zero-wait slaves.
- Data-phase completion (data phase valid, hready high, hresp low):
  - req_hit[ch] is high combinationally that cycle.
  - req_rdata = hrdata.
  - Latency: hit arrives in the cycle after address acceptance, plus slave wait states.
- Error response (hresp high, two-cycle):
  - First cycle (hready low): htrans is forced to IDLE for the next cycle; any pipelined address not yet accepted is cancelled and re-arbitrated later.
  - Second cycle (hready high): req_hit[ch] and req_err[ch] are both high.
- Misaligned request (half with addr[0]=1, word with addr[1:0]!=0):
  - No bus transfer is issued.
  - When granted in a cycle where no NONSEQ is pending, req_hit and req_err pulse in the following cycle.
  - The channel then leaves arbitration.
- Arbitration:
  - ARB_MODE 0: fixed priority, lowest index wins.
  - ARB_MODE 1: priority starts at the rr pointer and wraps modulo NCH; after an acceptance the pointer advances to granted+1, wrapping to 0 at NCH.
  - A channel that hits is not re-granted in the same cycle; it is re-eligible the next cycle if still requesting.
- No requests: htrans=IDLE; haddr holds its last value.
- Request withdrawn after address acceptance: the data phase still completes on the bus and the hit pulse is still generated.
- Reset asserted mid-transfer: htrans=IDLE at the next edge; the in-flight transfer is abandoned and no hit is generated.

Test Plan:
- Ch0 read 0x100, zero-wait slave, hrdata=0xDEADBEEF -> NONSEQ hsize=010 in cycle 1, req_hit[0] with req_rdata=0xDEADBEEF in cycle 2.
- Ch0 read + ch1 word write 0x200/0x12345678 together, ARB_MODE 0 -> ch0 address cycle 1, ch1 address cycle 2 overlapping ch0 data, hwdata=0x12345678 cycle 3, hits in cycles 2 and 3.
- ARB_MODE 1, both channels requesting continuously -> grants alternate 0,1,0,1.
- Ch1 byte write, slave inserts 2 wait states -> haddr/hsize=000 held while hready low, single req_hit[1] after the waits.
- Ch0 read gets an error (hresp high 2 cycles) while ch1 is pipelined -> htrans IDLE, req_hit[0] and req_err[0] together, ch1 reissued afterwards.
- Ch1 half write at 0x201 -> no NONSEQ issued, req_hit[1]=req_err[1]=1 the next cycle. Separately, rst asserted mid-wait -> htrans=IDLE and all hits 0 the next cycle.

Source files
------------

// File: rtl/ahb_lite_multi_master_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_multi_master_if
//
// AHB-Lite master-port bundle used by ahb_lite_multi_master.
//
// Signals:
//   haddr   AW   address phase address
//   htrans  2    transfer type (IDLE 00 / NONSEQ 10)
//   hwrite  1    write transfer
//   hsize   3    000 byte, 001 half, 010 word
//   hburst  3    always SINGLE (000)
//   hwdata  DW   write data, driven during the data phase
//   hrdata  DW   read data from the slave
//   hready  1    slave ready / transfer done
//   hresp   1    slave error response
//
// Modports:
//   master  drives the address/control/write-data side
//   slave   drives hrdata, hready and hresp
// ---------------------------------------------------------------------------
interface ahb_lite_multi_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_lite_multi_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_multi_master
//
// Arbitrates NCH request channels (channel 0 = instruction fetch by
// convention) onto a single AHB-Lite master port. The next transfer's
// address phase is overlapped with the current data phase, so zero-wait
// slaves complete one transfer per cycle across different channels.
// Completion and error are reported per channel as single-cycle pulses.
//
// Parameters:
//   NCH       number of request channels
//   AW        address width
//   DW        data width (only 32 is supported in this generation)
//   ARB_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_read   NCH      per-channel read request (word sized)
//   req_write  2*NCH    per-channel write size: 00 none, 01 byte, 10 half, 11 word
//   req_addr   AW*NCH   per-channel address
//   req_wdata  DW*NCH   per-channel store data, byte-lane aligned
//   req_hit    NCH      completion pulse (combinational on the completing cycle)
//   req_err    NCH      error flag, coincident with req_hit
//   req_rdata  DW       read data, valid with a read's req_hit
//   ahb        AHB-Lite master modport
// ---------------------------------------------------------------------------
module ahb_lite_multi_master #(
  parameter int NCH      = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req_read,
  input  logic [2*NCH-1:0]       req_write,
  input  logic [AW*NCH-1:0]      req_addr,
  input  logic [DW*NCH-1:0]      req_wdata,
  output logic [NCH-1:0]         req_hit,
  output logic [NCH-1:0]         req_err,
  output logic [DW-1:0]          req_rdata,
  ahb_lite_multi_master_if.master ahb
);

  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW1 = CW + 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  // Write size code to hsize; "none" (a read) maps to word.
  function automatic logic [2:0] req_size(input logic [1:0] wr);
    case (wr)
      2'b01:   req_size = HSIZE_BYTE;
      2'b10:   req_size = HSIZE_HALF;
      default: req_size = HSIZE_WORD;
    endcase
  endfunction

  // True when the address is not naturally aligned for the transfer size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_HALF: is_misaligned = lo[0];
      HSIZE_WORD: is_misaligned = (lo != 2'b00);
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

  // One-hot channel vector.
  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] ch);
    onehot     = '0;
    onehot[ch] = 1'b1;
  endfunction

  // (base + k) modulo NCH, for the rotating priority search.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int k);
    logic [CW1-1:0] sum;
    sum      = {1'b0, base} + CW1'(k);
    wrap_add = (sum >= CW1'(NCH)) ? CW'(sum - CW1'(NCH)) : sum[CW-1:0];
  endfunction

  // Channel after ch, wrapping to 0 past the last channel.
  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] ch);
    next_ch = (ch == LAST_CH) ? '0 : ch + CW'(1);
  endfunction

  // Address-phase registers (these drive the bus directly).
  logic [AW-1:0] haddr_r;
  logic [1:0]    htrans_r;
  logic          hwrite_r;
  logic [2:0]    hsize_r;
  logic [CW-1:0] a_ch_r;

  // Data-phase registers.
  logic          d_valid_r;
  logic [CW-1:0] d_ch_r;
  logic [DW-1:0] hwdata_r;

  // Misaligned request being retired without a bus transfer.
  logic          mis_valid_r;
  logic [CW-1:0] mis_ch_r;

  logic [CW-1:0] rr_ptr_r;

  // Per-channel request decode.
  logic [NCH-1:0] ch_valid_s;
  logic [NCH-1:0] ch_write_s;
  logic [NCH-1:0] ch_misal_s;
  logic [2:0]     ch_size_s  [NCH];
  logic [AW-1:0]  ch_addr_s  [NCH];
  logic [DW-1:0]  ch_wdata_s [NCH];

  logic           accept_s;
  logic           complete_s;
  logic           err_first_s;
  logic [NCH-1:0] busy_s;
  logic [NCH-1:0] eligible_s;
  logic           gnt_valid_s;
  logic [CW-1:0]  gnt_ch_s;
  logic [CW-1:0]  cand_s;
  logic           take_s;

  // Split the flat request buses into per-channel fields.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_addr_s[i]  = req_addr[AW*i +: AW];
      ch_wdata_s[i] = req_wdata[DW*i +: DW];
      ch_write_s[i] = (req_write[2*i +: 2] != 2'b00);
      ch_valid_s[i] = req_read[i] | ch_write_s[i];
      ch_size_s[i]  = req_size(req_write[2*i +: 2]);
      ch_misal_s[i] = is_misaligned(ch_size_s[i], ch_addr_s[i][1:0]);
    end
  end

  assign accept_s    = (htrans_r == HTRANS_NONSEQ) && ahb.hready;
  assign complete_s  = d_valid_r && ahb.hready;
  // First cycle of a two-cycle error response.
  assign err_first_s = d_valid_r && !ahb.hready && ahb.hresp;

  // Channels that must not be granted this cycle: the one whose address is
  // being accepted (it moves into the data phase), the one completing now,
  // and a misaligned channel being retired now.
  assign busy_s = (accept_s    ? onehot(a_ch_r)   : '0)
                | (complete_s  ? onehot(d_ch_r)   : '0)
                | (mis_valid_r ? onehot(mis_ch_r) : '0);

  assign eligible_s = ch_valid_s & ~busy_s;

  // Priority search: from channel 0 (fixed) or from the rr pointer (round-robin).
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_ch_s    = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand_s      = (ARB_MODE == 1) ? wrap_add(rr_ptr_r, k) : CW'(k);
      take_s      = !gnt_valid_s && eligible_s[cand_s];
      gnt_ch_s    = take_s ? cand_s : gnt_ch_s;
      gnt_valid_s = gnt_valid_s | take_s;
    end
  end

  // Address phase: re-arbitrate only when hready is high; otherwise hold,
  // except that the first error cycle cancels any pending NONSEQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      htrans_r <= HTRANS_IDLE;
      haddr_r  <= '0;
      hwrite_r <= 1'b0;
      hsize_r  <= HSIZE_BYTE;
      a_ch_r   <= '0;
    end else if (ahb.hready) begin
      if (gnt_valid_s && !ch_misal_s[gnt_ch_s]) begin
        htrans_r <= HTRANS_NONSEQ;
        haddr_r  <= ch_addr_s[gnt_ch_s];
        hwrite_r <= ch_write_s[gnt_ch_s];
        hsize_r  <= ch_size_s[gnt_ch_s];
        a_ch_r   <= gnt_ch_s;
      end else begin
        htrans_r <= HTRANS_IDLE;
      end
    end else if (err_first_s) begin
      htrans_r <= HTRANS_IDLE;
    end
  end

  // Misaligned grant: retire the channel with hit+err on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_valid_r <= 1'b0;
      mis_ch_r    <= '0;
    end else begin
      mis_valid_r <= ahb.hready && gnt_valid_s && ch_misal_s[gnt_ch_s];
      mis_ch_r    <= gnt_ch_s;
    end
  end

  // Data phase: capture the accepted channel and its store data.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid_r <= 1'b0;
      d_ch_r    <= '0;
      hwdata_r  <= '0;
    end else if (accept_s) begin
      d_valid_r <= 1'b1;
      d_ch_r    <= a_ch_r;
      hwdata_r  <= ch_wdata_s[a_ch_r];
    end else if (ahb.hready) begin
      d_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer moves past the channel whose address was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= next_ch(a_ch_r);
    end
  end

  assign ahb.haddr  = haddr_r;
  assign ahb.htrans = htrans_r;
  assign ahb.hwrite = hwrite_r;
  assign ahb.hsize  = hsize_r;
  assign ahb.hburst = 3'b000;
  assign ahb.hwdata = hwdata_r;

  // Completion is reported in the cycle the slave finishes the data phase.
  assign req_hit   = (complete_s ? onehot(d_ch_r) : '0)
                   | (mis_valid_r ? onehot(mis_ch_r) : '0);
  assign req_err   = ((complete_s && ahb.hresp) ? onehot(d_ch_r) : '0)
                   | (mis_valid_r ? onehot(mis_ch_r) : '0);
  assign req_rdata = ahb.hrdata;

endmodule

// File: tb/tb_ahb_lite_multi_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_multi_master
//
// Directed bench for ahb_lite_multi_master. Two instances share the same
// request and slave-response stimulus: dut0 uses fixed priority and dut1
// round-robin. Inputs change 1 time unit after the rising edge and outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_multi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_read;
  logic [3:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  logic [1:0]  hit0, err0, hit1, err1;
  logic [31:0] rdata0, rdata1;

  int tests = 0;
  int fails = 0;

  ahb_lite_multi_master_if #(.AW(32), .DW(32)) bus0 ();
  ahb_lite_multi_master_if #(.AW(32), .DW(32)) bus1 ();

  assign bus0.hrdata = hrdata;
  assign bus0.hready = hready;
  assign bus0.hresp  = hresp;
  assign bus1.hrdata = hrdata;
  assign bus1.hready = hready;
  assign bus1.hresp  = hresp;

  ahb_lite_multi_master #(.NCH(2), .AW(32), .DW(32), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_hit(hit0), .req_err(err0),
    .req_rdata(rdata0), .ahb(bus0)
  );

  ahb_lite_multi_master #(.NCH(2), .AW(32), .DW(32), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_hit(hit1), .req_err(err1),
    .req_rdata(rdata1), .ahb(bus1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_read = 2'b00; req_write = 4'b0000; req_addr = '0; req_wdata = '0;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    step(); step(); mid();
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans0: got %b expected 00", bus0.htrans); end
    tests++; if (bus0.haddr !== 32'h0) begin fails++; $display("FAIL rst_haddr0: got %h expected 0", bus0.haddr); end
    tests++; if ({bus0.hwrite, bus0.hsize, bus0.hburst} !== 7'b0) begin fails++; $display("FAIL rst_ctrl0: got %b expected 0", {bus0.hwrite, bus0.hsize, bus0.hburst}); end
    tests++; if (bus0.hwdata !== 32'h0) begin fails++; $display("FAIL rst_hwdata0: got %h expected 0", bus0.hwdata); end
    tests++; if ({hit0, err0, hit1, err1} !== 8'b0) begin fails++; $display("FAIL rst_hits: got %b expected 0", {hit0, err0, hit1, err1}); end
    tests++; if (bus1.htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans1: got %b expected 00", bus1.htrans); end
    step(); rst = 1'b0;
  endtask

  task automatic test_single_read();
    step(); req_read = 2'b01; req_addr[31:0] = 32'h100; hrdata = 32'hDEADBEEF; mid();
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL rd_c0_htrans: got %b expected 00", bus0.htrans); end
    step(); mid();
    tests++; if (bus0.htrans !== 2'b10) begin fails++; $display("FAIL rd_c1_htrans: got %b expected 10", bus0.htrans); end
    tests++; if (bus0.haddr !== 32'h100) begin fails++; $display("FAIL rd_c1_haddr: got %h expected 100", bus0.haddr); end
    tests++; if ({bus0.hwrite, bus0.hsize} !== 4'b0010) begin fails++; $display("FAIL rd_c1_ctrl: got %b expected 0010", {bus0.hwrite, bus0.hsize}); end
    tests++; if (hit0 !== 2'b00) begin fails++; $display("FAIL rd_c1_hit: got %b expected 00", hit0); end
    step(); mid();
    tests++; if (hit0 !== 2'b01) begin fails++; $display("FAIL rd_c2_hit: got %b expected 01", hit0); end
    tests++; if (err0 !== 2'b00) begin fails++; $display("FAIL rd_c2_err: got %b expected 00", err0); end
    tests++; if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_c2_rdata: got %h expected deadbeef", rdata0); end
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL rd_c2_htrans: got %b expected 00", bus0.htrans); end
    step(); req_read = 2'b00; mid();
    tests++; if (hit0 !== 2'b00) begin fails++; $display("FAIL rd_c3_hit: got %b expected 00", hit0); end
  endtask

  task automatic test_pipelined();
    step();
    req_read = 2'b01; req_addr[31:0] = 32'h100;
    req_write = 4'b1100; req_addr[63:32] = 32'h200; req_wdata[63:32] = 32'h12345678;
    hrdata = 32'hCAFEF00D;
    mid();
    step(); mid();
    tests++; if (bus0.haddr !== 32'h100 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL pipe_c1_addr: got %h/%b expected 100/10", bus0.haddr, bus0.htrans); end
    step(); mid();
    tests++; if (bus0.haddr !== 32'h200 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL pipe_c2_addr: got %h/%b expected 200/10", bus0.haddr, bus0.htrans); end
    tests++; if ({bus0.hwrite, bus0.hsize} !== 4'b1010) begin fails++; $display("FAIL pipe_c2_ctrl: got %b expected 1010", {bus0.hwrite, bus0.hsize}); end
    tests++; if (hit0 !== 2'b01 || rdata0 !== 32'hCAFEF00D) begin fails++; $display("FAIL pipe_c2_hit: got %b/%h expected 01/cafef00d", hit0, rdata0); end
    step(); req_read = 2'b00; mid();
    tests++; if (bus0.hwdata !== 32'h12345678) begin fails++; $display("FAIL pipe_c3_hwdata: got %h expected 12345678", bus0.hwdata); end
    tests++; if (hit0 !== 2'b10 || err0 !== 2'b00) begin fails++; $display("FAIL pipe_c3_hit: got %b/%b expected 10/00", hit0, err0); end
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL pipe_c3_htrans: got %b expected 00", bus0.htrans); end
    step(); req_write = 4'b0000; mid();
    tests++; if (hit0 !== 2'b00) begin fails++; $display("FAIL pipe_c4_hit: got %b expected 00", hit0); end
  endtask

  task automatic test_round_robin();
    logic [31:0] seen [4];
    logic [31:0] exp_seq [4];
    int n;
    n = 0;
    exp_seq[0] = 32'h300; exp_seq[1] = 32'h400; exp_seq[2] = 32'h300; exp_seq[3] = 32'h400;
    for (int i = 0; i < 4; i++) seen[i] = 32'h0;
    step(); req_read = 2'b11; req_addr = {32'h400, 32'h300};
    for (int c = 0; c < 12; c++) begin
      mid();
      if (bus1.htrans == 2'b10 && n < 4) begin seen[n] = bus1.haddr; n++; end
      step();
    end
    req_read = 2'b00;
    step(); step(); step();
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_grant_count: got %0d expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (seen[i] !== exp_seq[i]) begin fails++; $display("FAIL rr_grant_%0d: got %h expected %h", i, seen[i], exp_seq[i]); end
    end
    // ch0 alone first so the rr pointer moves to 1, then both request at once.
    req_read = 2'b01; req_addr = {32'h600, 32'h500};
    step(); step(); step();
    req_read = 2'b11; mid();
    tests++; if (bus1.htrans !== 2'b00 || bus0.htrans !== 2'b00) begin fails++; $display("FAIL rr_idle: got %b/%b expected 00/00", bus0.htrans, bus1.htrans); end
    step(); mid();
    tests++; if (bus0.haddr !== 32'h500 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL fixed_prio_grant: got %h/%b expected 500/10", bus0.haddr, bus0.htrans); end
    tests++; if (bus1.haddr !== 32'h600 || bus1.htrans !== 2'b10) begin fails++; $display("FAIL rr_ptr_grant: got %h/%b expected 600/10", bus1.haddr, bus1.htrans); end
    step(); req_read = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_wait_states();
    step();
    req_read = 2'b00; req_write = 4'b0100; req_addr[63:32] = 32'h203; req_wdata[63:32] = 32'hAB000000;
    hready = 1'b1; mid();
    step(); hready = 1'b0; mid();
    tests++; if (bus0.htrans !== 2'b10 || bus0.haddr !== 32'h203) begin fails++; $display("FAIL ws_c1_addr: got %b/%h expected 10/203", bus0.htrans, bus0.haddr); end
    tests++; if ({bus0.hwrite, bus0.hsize} !== 4'b1000) begin fails++; $display("FAIL ws_c1_ctrl: got %b expected 1000", {bus0.hwrite, bus0.hsize}); end
    step(); req_read = 2'b01; req_addr[31:0] = 32'h104; mid();
    tests++; if (bus0.haddr !== 32'h203 || bus0.hsize !== 3'b000 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL ws_c2_hold: got %h/%b/%b expected 203/000/10", bus0.haddr, bus0.hsize, bus0.htrans); end
    tests++; if (hit0 !== 2'b00) begin fails++; $display("FAIL ws_c2_hit: got %b expected 00", hit0); end
    step(); hready = 1'b1; mid();
    tests++; if (bus0.haddr !== 32'h203 || hit0 !== 2'b00) begin fails++; $display("FAIL ws_c3_hold: got %h/%b expected 203/00", bus0.haddr, hit0); end
    step(); mid();
    tests++; if (hit0 !== 2'b10 || err0 !== 2'b00) begin fails++; $display("FAIL ws_c4_hit: got %b/%b expected 10/00", hit0, err0); end
    tests++; if (bus0.hwdata !== 32'hAB000000) begin fails++; $display("FAIL ws_c4_hwdata: got %h expected ab000000", bus0.hwdata); end
    tests++; if (bus0.haddr !== 32'h104 || bus0.htrans !== 2'b10 || bus0.hsize !== 3'b010) begin fails++; $display("FAIL ws_c4_next: got %h/%b/%b expected 104/10/010", bus0.haddr, bus0.htrans, bus0.hsize); end
    step(); req_write = 4'b0000; mid();
    tests++; if (hit0 !== 2'b01) begin fails++; $display("FAIL ws_c5_hit: got %b expected 01", hit0); end
    step(); req_read = 2'b00; mid();
    tests++; if (hit0 !== 2'b00) begin fails++; $display("FAIL ws_c6_hit: got %b expected 00", hit0); end
  endtask

  task automatic test_error();
    step(); req_read = 2'b11; req_addr = {32'h210, 32'h110}; hready = 1'b1; hresp = 1'b0; mid();
    step(); mid();
    tests++; if (bus0.haddr !== 32'h110 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL err_c1_addr: got %h/%b expected 110/10", bus0.haddr, bus0.htrans); end
    step(); hready = 1'b0; hresp = 1'b1; mid();
    tests++; if (bus0.haddr !== 32'h210 || bus0.htrans !== 2'b10) begin fails++; $display("FAIL err_c2_addr: got %h/%b expected 210/10", bus0.haddr, bus0.htrans); end
    tests++; if (hit0 !== 2'b00 || err0 !== 2'b00) begin fails++; $display("FAIL err_c2_hit: got %b/%b expected 00/00", hit0, err0); end
    step(); hready = 1'b1; mid();
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL err_c3_htrans: got %b expected 00", bus0.htrans); end
    tests++; if (hit0 !== 2'b01 || err0 !== 2'b01) begin fails++; $display("FAIL err_c3_hit: got %b/%b expected 01/01", hit0, err0); end
    step(); hresp = 1'b0; req_read = 2'b10; mid();
    tests++; if (bus0.haddr !== 32'h210 || bus0.htrans !== 2'b10 || hit0 !== 2'b00) begin fails++; $display("FAIL err_c4_reissue: got %h/%b/%b expected 210/10/00", bus0.haddr, bus0.htrans, hit0); end
    step(); mid();
    tests++; if (hit0 !== 2'b10 || err0 !== 2'b00) begin fails++; $display("FAIL err_c5_hit: got %b/%b expected 10/00", hit0, err0); end
    step(); req_read = 2'b00; mid();
  endtask

  task automatic test_misaligned();
    step(); req_write = 4'b1000; req_addr[63:32] = 32'h201; mid();
    step(); mid();
    tests++; if (bus0.htrans !== 2'b00) begin fails++; $display("FAIL mis_half_htrans: got %b expected 00", bus0.htrans); end
    tests++; if (hit0 !== 2'b10 || err0 !== 2'b10) begin fails++; $display("FAIL mis_half_hit: got %b/%b expected 10/10", hit0, err0); end
    step(); req_write = 4'b0000; mid();
    tests++; if (hit0 !== 2'b00 || bus0.htrans !== 2'b00) begin fails++; $display("FAIL mis_half_after: got %b/%b expected 00/00", hit0, bus0.htrans); end
    step(); req_read = 2'b01; req_addr[31:0] = 32'h102; mid();
    step(); mid();
    tests++; if (hit0 !== 2'b01 || err0 !== 2'b01 || bus0.htrans !== 2'b00) begin fails++; $display("FAIL mis_word: got %b/%b/%b expected 01/01/00", hit0, err0, bus0.htrans); end
    step(); req_read = 2'b00; mid();
  endtask

  task automatic test_reset_mid();
    step(); req_read = 2'b11; req_addr = {32'h220, 32'h120}; hready = 1'b1; mid();
    step(); mid();
    step(); hready = 1'b0; rst = 1'b1; mid();
    step(); rst = 1'b0; hready = 1'b1; mid();
    tests++; if (bus0.htrans !== 2'b00 || bus0.haddr !== 32'h0) begin fails++; $display("FAIL rstmid_bus: got %b/%h expected 00/0", bus0.htrans, bus0.haddr); end
    tests++; if ({hit0, err0, hit1, err1} !== 8'b0) begin fails++; $display("FAIL rstmid_hits: got %b expected 0", {hit0, err0, hit1, err1}); end
    step(); req_read = 2'b00;
    step(); step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_pipelined();
    test_round_robin();
    test_wait_states();
    test_error();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
